// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronises the PLL lock flag, holds the system in
// reset until lock has been stable for STABLE_CYCLES plus HOLD_CYCLES, and
// re-asserts reset on loss of lock or a soft-reset request. It also counts
// lock losses seen while running.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       force_reset,
    output logic       sys_reset,
    output logic       sys_resetn,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STABLE  = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;

    logic locked_s;
    logic abort;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign abort    = !locked_s || force_reset;

    // Synchroniser shift, sequencing FSM, loss counter and next-state-derived outputs
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], locked};
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_d      = loss_q;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;

        case (state_q)
            S_HOLD: begin
                cnt_d = '0;
                if (!abort) begin
                    state_d = S_STABLE;
                end
            end
            S_STABLE: begin
                if (abort) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (abort) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (abort) begin
                    state_d = S_HOLD;
                end
                // Only a genuine lock drop counts; a soft reset alone does not
                if (!locked_s && (loss_q != 8'hFF)) begin
                    loss_d = loss_q + 8'd1;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase

        // Registering from next state makes reset assert on the edge RUN is left
        sys_reset_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    // State and output registers, forced to the held-in-reset values asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            loss_q      <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    assign sys_reset       = sys_reset_q;
    assign sys_resetn      = ~sys_reset_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC=2, STABLE=8, HOLD=4.
module tb_pll_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       locked;
    logic       force_reset;
    logic       sys_reset;
    logic       sys_resetn;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    int n_tests;
    int n_fail;
    int edges;

    pll_reset_sequencer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (4),
        .CNT_W        (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .force_reset    (force_reset),
        .sys_reset      (sys_reset),
        .sys_resetn     (sys_resetn),
        .ready          (ready),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Count edges (including the first) until sys_reset drops; 200 means timeout
    task automatic wait_release(output int n);
        n = 0;
        while (sys_reset && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_run(input string tag);
        check({tag, "_rst"},   32'(sys_reset),  32'd0);
        check({tag, "_rstn"},  32'(sys_resetn), 32'd1);
        check({tag, "_ready"}, 32'(ready),      32'd1);
        check({tag, "_state"}, 32'(state),      32'd3);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        locked      = 1'b0;
        force_reset = 1'b0;

        // Reset values visible before any clock edge
        #3;
        check("por_rst",   32'(sys_reset),       32'd1);
        check("por_rstn",  32'(sys_resetn),      32'd0);
        check("por_ready", 32'(ready),           32'd0);
        check("por_state", 32'(state),           32'd0);
        check("por_count", 32'(lock_loss_count), 32'd0);
        tick();
        reset = 1'b0;

        // 1: no lock keeps the system held
        repeat (50) tick();
        check("t1_state", 32'(state),     32'd0);
        check("t1_rst",   32'(sys_reset), 32'd1);
        check("t1_ready", 32'(ready),     32'd0);

        // 2: first lock; release exactly at edge N+14
        locked = 1'b1;
        repeat (14) tick();
        check("t2_held_n13", 32'(sys_reset), 32'd1);
        check("t2_ready_n13", 32'(ready),    32'd0);
        tick();
        check_run("t2_n14");

        // 3: lock glitch during STABLE restarts the sequence
        reset = 1'b1;
        #1;
        reset = 1'b0;
        locked = 1'b0;
        repeat (5) tick();
        locked = 1'b1;
        repeat (3) tick();
        check("t3_in_stable", 32'(state), 32'd1);
        repeat (5) tick();
        locked = 1'b0;
        tick();                    // edge X samples the drop
        locked = 1'b1;
        tick();                    // edge X+1: first sample of restored lock
        tick();                    // edge X+2: abort seen
        check("t3_back_hold", 32'(state), 32'd0);
        wait_release(edges);
        check("t3_release_edges", 32'(edges), 32'd13);
        check_run("t3_run");
        check("t3_count", 32'(lock_loss_count), 32'd0);

        // 4: three lock drops while running
        for (int k = 0; k < 3; k++) begin
            locked = 1'b0;
            tick();
            tick();
            check("t4_still_run", 32'(sys_reset), 32'd0);
            tick();
            check("t4_reasserted", 32'(sys_reset), 32'd1);
            check("t4_ready_low",  32'(ready),     32'd0);
            locked = 1'b1;
            wait_release(edges);
            check("t4_recover_edges", 32'(edges), 32'd15);
        end
        check("t4_count", 32'(lock_loss_count), 32'd3);

        // 5: one-cycle soft reset
        force_reset = 1'b1;
        tick();
        check("t5_rst",   32'(sys_reset), 32'd1);
        check("t5_state", 32'(state),     32'd0);
        force_reset = 1'b0;
        wait_release(edges);
        check("t5_recover_edges", 32'(edges), 32'd13);
        check("t5_count", 32'(lock_loss_count), 32'd3);

        // 6: many losses saturate the counter
        for (int k = 0; k < 297; k++) begin
            locked = 1'b0;
            repeat (3) tick();
            locked = 1'b1;
            wait_release(edges);
            if (edges >= 200) begin
                check("t6_recover_timeout", 32'(edges), 32'd15);
                break;
            end
        end
        check("t6_saturated", 32'(lock_loss_count), 32'd255);
        check_run("t6_run");

        // Async reset in the middle of RELEASE
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        edges = 0;
        while (state != 2'd2 && edges < 40) begin
            tick();
            edges++;
        end
        check("t6_in_release", 32'(state), 32'd2);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("t6_ar_rst",   32'(sys_reset),       32'd1);
        check("t6_ar_rstn",  32'(sys_resetn),      32'd0);
        check("t6_ar_ready", 32'(ready),           32'd0);
        check("t6_ar_state", 32'(state),           32'd0);
        check("t6_ar_count", 32'(lock_loss_count), 32'd0);
        tick();
        reset = 1'b0;
        wait_release(edges);
        check("t6_after_reset_edges", 32'(edges), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
